// File: rtl/slave_sched_pkg.sv
// rtl/slave_sched_pkg.sv - shared types and constants for per-slave schedulers
package slave_sched_pkg;

  typedef enum logic [1:0] {IDLE, WAIT_ACK, WAIT_RESP} state_e;

  localparam logic CMD_READ  = 1'b0;
  localparam logic CMD_WRITE = 1'b1;

  localparam int TX_AW = 30;
  localparam int TX_DW = 32;

  typedef struct packed {
    logic             cmd;
    logic [TX_AW-1:0] addr;
    logic [TX_DW-1:0] wdata;
  } tx_t;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin pick starting after the last winner
module rr_pick #(
  parameter int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [N-1:0]  mask_i,
  input  logic [IW-1:0] last_i,
  output logic          found_o,
  output logic [IW-1:0] index_o
);

  logic [N-1:0]  elig;
  logic [IW-1:0] cand;

  assign elig = req_i & ~mask_i;

  // N is a power of two, so the IW-bit add wraps modulo N; i==N revisits last_i itself
  always_comb begin
    found_o = 1'b0;
    index_o = '0;
    cand    = '0;
    for (int i = 1; i <= N; i++) begin
      cand = last_i + IW'(i);
      if (!found_o && elig[cand]) begin
        found_o = 1'b1;
        index_o = cand;
      end
    end
  end

endmodule

// File: rtl/slave_rr_sched.sv
// rtl/slave_rr_sched.sv - round-robin scheduler sharing one slave port among masters
module slave_rr_sched
  import slave_sched_pkg::*;
#(
  parameter int MASTERS = 4,
  parameter int AW      = TX_AW,
  parameter int DW      = TX_DW,
  parameter int TIMEOUT = 255,
  localparam int IW     = $clog2(MASTERS)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [MASTERS-1:0]          m_req,
  input  logic [MASTERS-1:0]          m_cmd,
  input  logic [MASTERS-1:0][AW-1:0]  m_addr,
  input  logic [MASTERS-1:0][DW-1:0]  m_wdata,
  output logic [MASTERS-1:0]          m_ack,
  output logic [MASTERS-1:0]          m_resp,
  output logic [MASTERS-1:0]          m_err,
  output logic [DW-1:0]               m_rdata,
  output logic                        s_req,
  output logic                        s_cmd,
  output logic [AW-1:0]               s_addr,
  output logic [DW-1:0]               s_wdata,
  input  logic                        s_ack,
  input  logic                        s_resp,
  input  logic [DW-1:0]               s_rdata,
  output logic                        busy,
  output logic [IW-1:0]               grant_id
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  state_e             state_q;
  logic [IW-1:0]      grant_q, last_q;
  logic [MASTERS-1:0] excl_q, m_ack_q, m_resp_q, m_err_q;
  logic [DW-1:0]      m_rdata_q, s_wdata_q;
  logic               s_req_q, s_cmd_q;
  logic [AW-1:0]      s_addr_q;
  logic [CW-1:0]      cnt_q;

  logic               pick_found;
  logic [IW-1:0]      pick_idx;
  logic [MASTERS-1:0] grant_oh;
  logic               expire;
  tx_t                sel_tx;

  rr_pick #(.N(MASTERS)) u_pick (
    .req_i   (m_req),
    .mask_i  (excl_q),
    .last_i  (last_q),
    .found_o (pick_found),
    .index_o (pick_idx)
  );

  always_comb begin
    sel_tx.cmd   = m_cmd[pick_idx];
    sel_tx.addr  = TX_AW'(m_addr[pick_idx]);
    sel_tx.wdata = TX_DW'(m_wdata[pick_idx]);
  end

  assign grant_oh = MASTERS'(1) << grant_q;
  // Expiry fires on the edge that would take the counter to TIMEOUT
  assign expire   = (TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      last_q    <= IW'(MASTERS - 1);
      excl_q    <= '0;
      m_ack_q   <= '0;
      m_resp_q  <= '0;
      m_err_q   <= '0;
      m_rdata_q <= '0;
      s_req_q   <= 1'b0;
      s_cmd_q   <= 1'b0;
      s_addr_q  <= '0;
      s_wdata_q <= '0;
      cnt_q     <= '0;
    end else begin
      s_req_q   <= 1'b0;
      m_ack_q   <= '0;
      m_resp_q  <= '0;
      m_err_q   <= '0;
      m_rdata_q <= '0;
      excl_q    <= '0;
      unique case (state_q)
        IDLE: begin
          if (pick_found) begin
            grant_q  <= pick_idx;
            last_q   <= pick_idx;
            s_cmd_q  <= sel_tx.cmd;
            s_addr_q <= AW'(sel_tx.addr);
            if (sel_tx.cmd == CMD_WRITE) s_wdata_q <= DW'(sel_tx.wdata);
            s_req_q  <= 1'b1;
            cnt_q    <= '0;
            state_q  <= WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          if (s_ack) begin
            m_ack_q <= grant_oh;
            if (s_cmd_q == CMD_WRITE) begin
              state_q <= IDLE;
              excl_q  <= grant_oh;
            end else if (s_resp) begin
              m_resp_q  <= grant_oh;
              m_rdata_q <= s_rdata;
              state_q   <= IDLE;
              excl_q    <= grant_oh;
            end else begin
              cnt_q   <= '0;
              state_q <= WAIT_RESP;
            end
          end else if (expire) begin
            m_ack_q <= grant_oh;
            m_err_q <= grant_oh;
            if (s_cmd_q == CMD_READ) m_resp_q <= grant_oh;
            state_q <= IDLE;
            excl_q  <= grant_oh;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        WAIT_RESP: begin
          if (s_resp) begin
            m_resp_q  <= grant_oh;
            m_rdata_q <= s_rdata;
            state_q   <= IDLE;
            excl_q    <= grant_oh;
          end else if (expire) begin
            m_resp_q <= grant_oh;
            m_err_q  <= grant_oh;
            state_q  <= IDLE;
            excl_q   <= grant_oh;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign m_ack    = m_ack_q;
  assign m_resp   = m_resp_q;
  assign m_err    = m_err_q;
  assign m_rdata  = m_rdata_q;
  assign s_req    = s_req_q;
  assign s_cmd    = s_cmd_q;
  assign s_addr   = s_addr_q;
  assign s_wdata  = s_wdata_q;
  assign busy     = (state_q != IDLE);
  assign grant_id = grant_q;

endmodule

// File: doc/slave_rr_sched.md
Name: slave_rr_sched

Overview:
- Per-slave scheduler: shares one slave port between MASTERS requesters using round-robin arbitration.
- Sequences each granted transaction through the slave req/ack/resp handshake and routes ack/resp/rdata back to the owning master.
- Adds a per-transaction timeout so a hung slave cannot lock the fabric.
- Sits between master-side request cells and one slave_if port; one instance per slave.

Parameters:
- MASTERS, 4, number of requesters (power of 2, >=2).
- AW, 30, slave-local address width (32 minus slave-select bits).
- DW, 32, data width.
- TIMEOUT, 255, max cycles in WAIT_ACK or WAIT_RESP before abort; 0 disables timeout.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- m_req  in  MASTERS  per-master request; held high until that master's m_ack.
- m_cmd  in  MASTERS  per-master command, 0=read, 1=write.
- m_addr  in  MASTERS x AW  per-master address.
- m_wdata  in  MASTERS x DW  per-master write data.
- m_ack  out  MASTERS  one-cycle accept pulse to the owning master.
- m_resp  out  MASTERS  one-cycle read-response pulse.
- m_err  out  MASTERS  one-cycle timeout flag; coincides with the m_ack or m_resp it qualifies.
- m_rdata  out  DW  read data, valid while any m_resp bit is high.
- s_req  out  1  one-cycle request pulse to the slave.
- s_cmd  out  1  command to the slave.
- s_addr  out  AW  address to the slave.
- s_wdata  out  DW  write data to the slave.
- s_ack  in  1  slave accept.
- s_resp  in  1  slave read response.
- s_rdata  in  DW  slave read data.
- busy  out  1  high in any state other than IDLE.
- grant_id  out  $clog2(MASTERS)  index of the current or last granted master.

Behaviour:
- Reset (async, rst=1): state=IDLE. All outputs 0. last_grant=MASTERS-1, so the first search starts at master 0. Timeout counter 0. Exclude mask 0.
- FSM states: IDLE, WAIT_ACK, WAIT_RESP. All outputs are registered.
- IDLE, arbitration:
  - Eligible set = m_req & ~excl_mask.
  - Pick the first eligible master scanning last_grant+1, last_grant+2, ... modulo MASTERS.
  - If one is found at edge k:
    - latch grant_id, s_cmd, s_addr, and s_wdata (s_wdata only when cmd=1; otherwise it holds its old value);
    - s_req=1 for cycle k+1 only;
    - last_grant=pick; timeout counter cleared; go WAIT_ACK.
  - If none is found, stay in IDLE.
- WAIT_ACK:
  - s_req=0.
  - On s_ack: m_ack[grant]=1 next cycle.
    - Write: go IDLE.
    - Read: go WAIT_RESP; counter cleared.
  - Read with s_ack and s_resp in the same cycle: m_ack and m_resp pulse together, m_rdata=s_rdata, go IDLE.
- WAIT_RESP: on s_resp, m_resp[grant]=1 and m_rdata=s_rdata for one cycle; go IDLE.
- Timeout:
  - Counter increments each cycle in WAIT_ACK/WAIT_RESP without the awaited event.
  - On reaching TIMEOUT with no event, pulse m_err[grant] together with:
    - m_ack[grant] in WAIT_ACK (for a read, also m_resp with m_rdata=0);
    - m_resp[grant] with m_rdata=0 in WAIT_RESP.
  - Then go IDLE.
  - An event arriving on the same edge as expiry wins: normal completion, no m_err.
- Completion masking:
  - On every return to IDLE, excl_mask = onehot(grant) for exactly one cycle, then clears.
  - This stops the just-served master's still-high m_req from being regranted.
  - The mask does not block other masters.
- Stray inputs: s_ack/s_resp in IDLE, or s_resp in WAIT_ACK for a write, are ignored.
- m_req changes: m_req deassertion after grant does not cancel the transaction; the block samples m_req only in IDLE.
- Fairness: with all masters requesting continuously, grants rotate 0,1,2,3,0,... No master waits more than MASTERS-1 transactions.
- Minimum write occupancy: grant edge, s_req cycle, ack cycle, 1 mask cycle.

Decomposition:
- Shared package slave_sched_pkg:
  - state enum {IDLE, WAIT_ACK, WAIT_RESP};
  - CMD_READ=0, CMD_WRITE=1 constants;
  - tx struct {cmd, addr, wdata}.
- One sub-module rr_pick: combinational, with inputs req vector, mask, last pointer; outputs found and index. It is reused by other arbiters.

Test Plan:
- Single write: m_req[2]=1, cmd=1, addr=0x10, wdata=0xA5A5 -> s_req pulse next cycle with matching fields. s_ack 3 cycles later -> m_ack[2] one cycle later. No m_resp, no m_err.
- Read: m_req[1] read, addr=0x4. Slave acks, then resp with rdata=0xDEADBEEF 5 cycles later -> m_ack[1] pulse, then m_resp[1] with m_rdata=0xDEADBEEF. busy low afterwards.
- Fairness: all four m_req held high, slave acks writes immediately -> grant_id sequence 0,1,2,3,0,1. Each master is granted once per four transactions.
- Timeout: TIMEOUT=8, read to master 3, slave never acks -> after 8 cycles in WAIT_ACK, m_ack[3], m_resp[3], and m_err[3] pulse with m_rdata=0, then IDLE.
- Simultaneous ack+resp on a read -> m_ack and m_resp pulse in the same cycle, state returns to IDLE, no WAIT_RESP visit.
- Async reset asserted mid-WAIT_RESP -> all outputs 0 immediately without a clock edge. After release, the first grant goes to the lowest requesting master index.
